riscv_core_hs: RTL

- Parametrised successor to the team's 16-bit-instruction, 8-bit-datapath mini core.
- Register file width, register count and memory address width are generic.
- Instruction fetch uses a valid/ready handshake; data memory uses a req/ack handshake that tolerates wait states.
- Adds XOR, shifts, load-immediate, HALT, a retired-instruction counter and a debug register read port. Sits between the instruction source (testbench or fetch unit) and data memory.

---
 rtl/riscv_core_pkg.sv | 28 ++
 rtl/riscv_alu.sv | 36 +++
 rtl/riscv_core_hs.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the riscv_core_hs mini core: opcodes, FSM states
// and the instruction-width rule.
package riscv_core_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_LI    = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Instruction word is {opcode[3:0], rd, rs1, rs2}.
    function automatic int instr_w(input int reg_aw);
        return 4 + 3 * reg_aw;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational ALU for riscv_core_hs. Results wrap to DATA_W bits.
module riscv_alu
    import riscv_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh_amt;

    assign sh_amt = b[SH_W-1:0];

    // Select the operation result; non-ALU opcodes produce zero.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << sh_amt;
            OP_SHR:  result = a >> sh_amt;
            OP_LI:   result = imm;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/riscv_core_hs.sv
// riscv_core_hs: parametrised mini core with valid/ready instruction fetch,
// req/ack data memory, retired-instruction counter and debug register port.
module riscv_core_hs
    import riscv_core_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int REG_AW  = 4,
    parameter  int ADDR_W  = 4,
    parameter  int RET_W   = 16,
    localparam int INSTR_W = instr_w(REG_AW)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               halted,
    output logic [RET_W-1:0]   retired,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int NREG = 2 ** REG_AW;

    state_t              state;
    logic [DATA_W-1:0]   regs [NREG];
    logic [REG_AW-1:0]   pend_rd;

    logic [3:0]          op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [2*REG_AW-1:0] imm_raw;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   alu_res;

    assign {op, rd, rs1, rs2} = instr;
    assign opa      = regs[rs1];
    assign opb      = regs[rs2];
    assign imm_raw  = {rs1, rs2};
    assign imm      = DATA_W'(imm_raw);

    assign instr_ready = (state == IDLE);
    assign halted      = (state == HALT);
    assign dbg_data    = regs[dbg_addr];

    riscv_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (op),
        .a      (opa),
        .b      (opb),
        .imm    (imm),
        .result (alu_res)
    );

    // Core FSM: register file writes, memory handshake and retire counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pend_rd   <= '0;
            retired   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        case (op)
                            OP_LOAD, OP_STORE: begin
                                mem_req   <= 1'b1;
                                mem_we    <= (op == OP_STORE);
                                mem_addr  <= opa[ADDR_W-1:0];
                                mem_wdata <= (op == OP_STORE) ? regs[rd] : '0;
                                pend_rd   <= rd;
                                state     <= MEM;
                            end
                            OP_HALT: begin
                                retired <= retired + RET_W'(1);
                                state   <= HALT;
                            end
                            default: begin
                                // Opcodes 10-14 are NOPs: they only retire.
                                if (op <= OP_LI) begin
                                    regs[rd] <= alu_res;
                                end
                                retired <= retired + RET_W'(1);
                            end
                        endcase
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            regs[pend_rd] <= mem_rdata;
                        end
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        retired   <= retired + RET_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule
